// File: rtl/uart_fifo_ctrl.sv
// ============================================================================
// Module   : uart_fifo_ctrl
// Brief    : UART with TX/RX FIFOs, baud prescaler, oversampled receiver,
//            optional parity and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_ctrl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [W-1:0]            i_data,
  input  logic                    i_pop,
  output logic [W-1:0]            o_data,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_level
);
  localparam int c_AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [c_AW:0] r_wptr, r_rptr;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[c_AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_level = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]) && (r_wptr[c_AW] != r_rptr[c_AW]);
  assign o_data  = r_mem[r_rptr[c_AW-1:0]];
endmodule

module uart_fifo_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_WIDTH-1:0]          i_baud_div,
  input  logic                          i_parity_en,
  input  logic                          i_parity_odd,
  input  logic [DATA_BITS-1:0]          i_tx_data,
  input  logic                          i_tx_valid,
  output logic                          o_tx_ready,
  output logic [DATA_BITS-1:0]          o_rx_data,
  output logic                          o_rx_valid,
  input  logic                          i_rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   o_rx_level,
  input  logic                          i_err_clr,
  output logic                          o_frame_err,
  output logic                          o_parity_err,
  output logic                          o_overrun_err,
  output logic                          o_interrupt,
  input  logic                          i_rx,
  output logic                          o_tx
);
  localparam int c_OSW = $clog2(OVERSAMPLE);
  localparam int c_BW  = $clog2(DATA_BITS);
  localparam logic [c_OSW-1:0] c_OS_LAST  = c_OSW'(OVERSAMPLE - 1);
  localparam logic [c_OSW-1:0] c_OS_HALF  = c_OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_BW-1:0]  c_BIT_LAST = c_BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } t_state;

  // Baud prescaler; the divisor is re-latched only on reload.
  logic [DIV_WIDTH-1:0] r_div_cnt, r_div;
  logic                 w_tick;
  assign w_tick = (r_div_cnt == r_div);

  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_div_cnt <= '0;
      r_div     <= i_baud_div;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  logic                 w_tx_pop, w_txf_empty, w_txf_full;
  logic [DATA_BITS-1:0] w_txf_data;

  uart_fifo_ctrl_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .i_push(i_tx_valid && o_tx_ready), .i_data(i_tx_data), .i_pop(w_tx_pop),
    .o_data(w_txf_data), .o_empty(w_txf_empty), .o_full(w_txf_full), .o_level(o_tx_level)
  );
  assign o_tx_ready = !w_txf_full;

  t_state               r_tx_state, w_tx_state_n;
  logic [c_OSW-1:0]     r_tx_os, w_tx_os_n;
  logic [c_BW-1:0]      r_tx_bit, w_tx_bit_n;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_n;
  logic                 r_tx_par, w_tx_par_n, r_tx_pen, w_tx_pen_n;
  logic                 r_tx_have, w_tx_have_n, r_tx, w_tx_n, w_tx_bit_end;

  assign w_tx_bit_end = w_tick && (r_tx_os == c_OS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= S_IDLE;
      r_tx_os    <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_pen   <= 1'b0;
      r_tx_have  <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_os    <= w_tx_os_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
      r_tx_par   <= w_tx_par_n;
      r_tx_pen   <= w_tx_pen_n;
      r_tx_have  <= w_tx_have_n;
      r_tx       <= w_tx_n;
    end
  end

  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_os_n    = r_tx_os;
    w_tx_bit_n   = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    w_tx_par_n   = r_tx_par;
    w_tx_pen_n   = r_tx_pen;
    w_tx_have_n  = r_tx_have;
    w_tx_pop     = 1'b0;
    if (w_tick && (r_tx_state != S_IDLE)) w_tx_os_n = w_tx_bit_end ? '0 : r_tx_os + 1'b1;
    case (r_tx_state)
      S_IDLE: begin
        w_tx_os_n = '0;
        if (r_tx_have) begin
          if (w_tick) begin
            w_tx_state_n = S_START;
            w_tx_have_n  = 1'b0;
          end
        end else if (!w_txf_empty) begin
          w_tx_pop    = 1'b1;
          w_tx_have_n = 1'b1;
        end
      end
      S_START: if (w_tx_bit_end) begin
        w_tx_state_n = S_DATA;
        w_tx_bit_n   = '0;
      end
      S_DATA: if (w_tx_bit_end) begin
        w_tx_shift_n = r_tx_shift >> 1;
        if (r_tx_bit == c_BIT_LAST) w_tx_state_n = r_tx_pen ? S_PARITY : S_STOP;
        else                        w_tx_bit_n   = r_tx_bit + 1'b1;
      end
      S_PARITY: if (w_tx_bit_end) w_tx_state_n = S_STOP;
      S_STOP: if (w_tx_bit_end) begin
        // Chain straight into the next start bit when more data is queued.
        if (!w_txf_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_state_n = S_START;
        end else begin
          w_tx_state_n = S_IDLE;
        end
      end
      default: w_tx_state_n = S_IDLE;
    endcase
    if (w_tx_pop) begin
      w_tx_shift_n = w_txf_data;
      w_tx_pen_n   = i_parity_en;
      w_tx_par_n   = (^w_txf_data) ^ i_parity_odd;
    end
    case (w_tx_state_n)
      S_START:  w_tx_n = 1'b0;
      S_DATA:   w_tx_n = w_tx_shift_n[0];
      S_PARITY: w_tx_n = w_tx_par_n;
      default:  w_tx_n = 1'b1;
    endcase
  end
  assign o_tx = r_tx;

  logic r_rx_s1, r_rx_s2, r_rx_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= i_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  logic                 w_rx_push, w_rx_pop, w_rxf_empty, w_rxf_full;
  logic                 w_set_frame, w_set_par, w_set_ovr, w_rx_sample;
  t_state               r_rx_state, w_rx_state_n;
  logic [c_OSW-1:0]     r_rx_os, w_rx_os_n;
  logic [c_BW-1:0]      r_rx_bit, w_rx_bit_n;
  logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_n;
  logic                 r_rx_perr, w_rx_perr_n;

  uart_fifo_ctrl_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .i_push(w_rx_push), .i_data(r_rx_shift), .i_pop(w_rx_pop),
    .o_data(o_rx_data), .o_empty(w_rxf_empty), .o_full(w_rxf_full), .o_level(o_rx_level)
  );
  assign o_rx_valid = !w_rxf_empty;
  assign w_rx_pop   = o_rx_valid && i_rx_ready;

  // The start bit is checked half a bit in; every later sample is mid-bit.
  assign w_rx_sample = w_tick && (r_rx_os == ((r_rx_state == S_START) ? c_OS_HALF : c_OS_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= S_IDLE;
      r_rx_os    <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_perr  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_n;
      r_rx_os    <= w_rx_os_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n;
      r_rx_perr  <= w_rx_perr_n;
    end
  end

  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_os_n    = r_rx_os;
    w_rx_bit_n   = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_perr_n  = r_rx_perr;
    w_rx_push    = 1'b0;
    w_set_frame  = 1'b0;
    w_set_par    = 1'b0;
    w_set_ovr    = 1'b0;
    if (w_tick && (r_rx_state != S_IDLE)) w_rx_os_n = w_rx_sample ? '0 : r_rx_os + 1'b1;
    case (r_rx_state)
      S_IDLE: begin
        w_rx_os_n   = '0;
        w_rx_perr_n = 1'b0;
        if (r_rx_prev && !r_rx_s2) w_rx_state_n = S_START;
      end
      S_START: if (w_rx_sample) begin
        if (r_rx_s2) begin
          w_rx_state_n = S_IDLE;
        end else begin
          w_rx_state_n = S_DATA;
          w_rx_bit_n   = '0;
        end
      end
      S_DATA: if (w_rx_sample) begin
        w_rx_shift_n = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
        if (r_rx_bit == c_BIT_LAST) w_rx_state_n = i_parity_en ? S_PARITY : S_STOP;
        else                        w_rx_bit_n   = r_rx_bit + 1'b1;
      end
      S_PARITY: if (w_rx_sample) begin
        w_rx_perr_n  = r_rx_s2 != ((^r_rx_shift) ^ i_parity_odd);
        w_rx_state_n = S_STOP;
      end
      S_STOP: if (w_rx_sample) begin
        w_rx_state_n = S_IDLE;
        w_set_frame  = !r_rx_s2;
        w_set_par    = r_rx_perr;
        if (r_rx_s2 && !r_rx_perr) begin
          if (w_rxf_full && !w_rx_pop) w_set_ovr = 1'b1;
          else                         w_rx_push = 1'b1;
        end
      end
      default: w_rx_state_n = S_IDLE;
    endcase
  end

  logic r_frame_err, r_parity_err, r_overrun_err, r_irq;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun_err <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      r_frame_err   <= w_set_frame | (r_frame_err   & ~i_err_clr);
      r_parity_err  <= w_set_par   | (r_parity_err  & ~i_err_clr);
      r_overrun_err <= w_set_ovr   | (r_overrun_err & ~i_err_clr);
      r_irq         <= o_rx_valid | r_frame_err | r_parity_err | r_overrun_err;
    end
  end
  assign o_frame_err   = r_frame_err;
  assign o_parity_err  = r_parity_err;
  assign o_overrun_err = r_overrun_err;
  assign o_interrupt   = r_irq;
endmodule

`default_nettype wire
